dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the core's load/store port: accepts one request at a time from the datapath's memory stage. Each request carries an address, write data, a write enable and a funct3-encoded access size. The block performs the access against an internal word-organised RAM after a configurable number of wait states, then returns sign- or zero-extended load data with a one-cycle response pulse. It is the far end of the `aluoutM` / `writedataM` / `memwriteM` / `memsizeM` / `readdataM` interface.

## Interface
- `DEPTH_WORDS`, default 1024: RAM depth in 32-bit words; power of two, ≥ 4.
- `WAIT_CYCLES`, default 1: wait states between accept and commit; range 0–15.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; the byte/halfword is taken from the low lanes.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  3  funct3 encoding: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rdata`  out  32  extended load data; held until the next response.
- `fault`  out  1  misaligned access; qualified by `rsp_valid`.

## Operation
- FSM states: IDLE, BUSY, RESP.
- `req_ready` = 1 only in IDLE.
- Accept: an edge with `req_valid && req_ready`. On accept, latch `addr`, `wdata`, `we`, `size` and load the wait counter with `WAIT_CYCLES`. Request inputs are ignored outside IDLE.
- Transitions:
  - IDLE → BUSY on accept when `WAIT_CYCLES` > 0.
  - IDLE → RESP on accept when `WAIT_CYCLES` = 0.
  - BUSY: counter decrements each edge; BUSY → RESP on the edge where the counter reaches 0.
  - RESP → IDLE unconditionally after one cycle.
- Commit: the RAM read or write happens on the edge entering RESP.
- Word index: `addr[log2(DEPTH_WORDS)+1:2]`; upper address bits are ignored, so addresses wrap modulo RAM size.
- Stores write byte lanes only:
  - sb: lane = `addr[1:0]`.
  - sh: lanes `{addr[1],0}` and `{addr[1],1}`.
  - sw: all four lanes.
- Loads:
  - Select the byte or halfword by `addr[1:0]` / `addr[1]`.
  - lb/lh sign-extend; lbu/lhu zero-extend.
- Undefined `size` codes (011, 110, 111) are treated as lw/sw.
- `rdata` is registered at commit. A store response leaves `rdata` at 0.
- RAM contents are not reset.

## Timing
- Reset values:
  - state IDLE
  - `req_ready` = 1
  - `rsp_valid` = 0
  - `rdata` = 0
  - `fault` = 0
  - wait counter = 0
- Latency: an accept at edge k raises `rsp_valid` for the cycle after edge k+`WAIT_CYCLES`. The next accept is possible at edge k+`WAIT_CYCLES`+2.
- Throughput: one request per `WAIT_CYCLES`+2 cycles.
- `fault` is valid only with `rsp_valid`; it returns to 0 when leaving RESP.
- Reset mid-operation: asserted before the commit edge, the access is discarded and no RAM write occurs. Asserted at or after the commit edge, the write stands. No response is issued after reset.
- A load to the word written by the immediately preceding store returns the new data.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - Misaligned conditions: lh/lhu/sh with `addr[0]` = 1; lw/sw with `addr[1:0]` ≠ 00.
  - A misaligned access makes no RAM change, returns `rdata` = 0 and asserts `fault` = 1 with `rsp_valid`.
- `DMEM_MISALIGN_TRAP_EN` undefined:
  - Low address bits are masked to alignment (halfword `addr & ~1`, word `addr & ~3`).
  - The access proceeds normally and `fault` is tied to 0.

## Structure
- Package `dmem_pkg`:
  - size-code localparams (`SZ_B`, `SZ_H`, `SZ_W`, `SZ_BU`, `SZ_HU`)
  - state enum typedef `dmem_state_t`
- Sub-module `dmem_lane_align` (combinational), covering:
  - byte-enable generation
  - store data replication onto lanes
  - load lane select and extension
  - misalignment detect
- The top level owns the FSM, wait counter, request latches and RAM array.

## Test plan
- Reset released with `WAIT_CYCLES`=1 → `req_ready`=1, `rsp_valid`=0, `rdata`=0. Then sw `0xDEADBEEF` @0x10 followed by lw @0x10 → `rsp_valid` 2 cycles after each accept; load `rdata`=`0xDEADBEEF`.
- Extension: with word `0x80FF7F01` @0x20:
  - lb @0x23 → `0xFFFFFF80`
  - lbu @0x23 → `0x00000080`
  - lh @0x22 → `0xFFFF80FF`
  - lhu @0x20 → `0x00007F01`
- Partial store: word @0x30 = `0x11223344`, then sb `0x000000AA` @0x31 → lw @0x30 = `0x1122AA44`; sh `0x0000BEEF` @0x32 → `0xBEEFAA44`.
- Misaligned lw @0x41:
  - with the macro: `fault`=1, `rdata`=0, memory unchanged.
  - without the macro: word @0x40 is returned and `fault`=0.
- Back-to-back: `req_valid` held high → accepts only when `req_ready`=1, spaced `WAIT_CYCLES`+2 cycles apart. With `WAIT_CYCLES`=0, response in the cycle after accept.
- Reset during BUSY of sw `0x12345678` @0x50 (`WAIT_CYCLES`=3) → no `rsp_valid`; a subsequent lw @0x50 returns the prior contents.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size codes, FSM state type and size-decoding helpers for dmem_responder.
package dmem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } dmem_state_t;

    // Any code that is neither a byte nor a halfword access behaves as a word access.
    function automatic logic isByteSz(input logic [2:0] s);
        return s == SZ_B || s == SZ_BU;
    endfunction

    function automatic logic isHalfSz(input logic [2:0] s);
        return s == SZ_H || s == SZ_HU;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte enables, store lane replication, load extraction/extension, misalign detect.
// DMEM_MISALIGN_TRAP_EN selects trapping on misalignment instead of masking the low address bits.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addrLo,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] ramWord,
    output logic [3:0]  byteEn,
    output logic [31:0] wLanes,
    output logic [31:0] loadData,
    output logic        misaligned
);

    logic        isByte;
    logic        isHalf;
    logic        signExt;
    logic [1:0]  effLo;
    logic [31:0] shifted;

    always_comb begin
        isByte   = isByteSz(size);
        isHalf   = isHalfSz(size);
        signExt  = !size[2];
        effLo    = isByte ? addrLo : isHalf ? {addrLo[1], 1'b0} : 2'b00;
        byteEn   = isByte ? 4'b0001 << effLo : isHalf ? 4'b0011 << effLo : 4'b1111;
        wLanes   = isByte ? {4{wdata[7:0]}} : isHalf ? {2{wdata[15:0]}} : wdata;
        shifted  = ramWord >> {effLo, 3'b000};
        loadData = isByte ? {{24{signExt & shifted[7]}}, shifted[7:0]}
                 : isHalf ? {{16{signExt & shifted[15]}}, shifted[15:0]}
                 : ramWord;
`ifdef DMEM_MISALIGN_TRAP_EN
        misaligned = isHalf ? addrLo[0] : !isByte && addrLo != 2'b00;
`else
        misaligned = 1'b0;
`endif
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with wait states over a word RAM.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [2:0]  size,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        fault
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_t   state;
    dmem_state_t   nextState;
    logic [3:0]    waitCnt;
    logic [AW+1:0] addrQ;
    logic [31:0]   wdataQ;
    logic          weQ;
    logic [2:0]    sizeQ;
    logic [31:0]   ram [DEPTH_WORDS];

    logic          accept;
    logic          commit;
    logic [AW+1:0] curAddr;
    logic [31:0]   curWdata;
    logic          curWe;
    logic [2:0]    curSize;
    logic [AW-1:0] wordIdx;
    logic [3:0]    byteEn;
    logic [31:0]   wLanes;
    logic [31:0]   loadData;
    logic          misaligned;

    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign accept    = req_valid && req_ready;

    // With zero wait states the commit edge is the accept edge, so the live inputs are used.
    assign commit   = (state == BUSY && waitCnt == 4'd1) || (accept && WAIT_CYCLES == 0);
    assign curAddr  = state == IDLE ? addr[AW+1:0] : addrQ;
    assign curWdata = state == IDLE ? wdata : wdataQ;
    assign curWe    = state == IDLE ? we : weQ;
    assign curSize  = state == IDLE ? size : sizeQ;
    assign wordIdx  = curAddr[AW+1:2];

    dmem_lane_align uAlign (
        .addrLo     (curAddr[1:0]),
        .size       (curSize),
        .wdata      (curWdata),
        .ramWord    (ram[wordIdx]),
        .byteEn     (byteEn),
        .wLanes     (wLanes),
        .loadData   (loadData),
        .misaligned (misaligned)
    );

    always_comb begin
        nextState = commit ? RESP : accept ? BUSY : state == RESP ? IDLE : state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            waitCnt <= 4'd0;
            addrQ   <= '0;
            wdataQ  <= 32'd0;
            weQ     <= 1'b0;
            sizeQ   <= 3'd0;
            rdata   <= 32'd0;
            fault   <= 1'b0;
        end else begin
            state   <= nextState;
            waitCnt <= accept ? 4'(WAIT_CYCLES) : state == BUSY ? waitCnt - 4'd1 : waitCnt;
            if (accept) begin
                addrQ  <= addr[AW+1:0];
                wdataQ <= wdata;
                weQ    <= we;
                sizeQ  <= size;
            end
            if (commit)
                rdata <= (curWe || misaligned) ? 32'd0 : loadData;
            fault <= commit && misaligned;
        end
    end

    // RAM contents survive reset; the reset term only blocks a commit racing a reset edge.
    always_ff @(posedge clk) begin
        if (reset && commit && curWe && !misaligned)
            for (int i = 0; i < 4; i++)
                if (byteEn[i])
                    ram[wordIdx][8*i +: 8] <= wLanes[8*i +: 8];
    end

endmodule
